// File: rtl/dsp_pkg.sv
// Shared DSP definitions: decimator state encoding and default sizing.
package dsp_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DECIMATION = 4;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } dec_state_t;

endpackage

// File: rtl/sample_decimator_if.sv
// Decimator bus: upstream FIFO read side and downstream result side.
interface sample_decimator_if
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                         read_request;
  logic                         input_valid;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         output_valid;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         ready_for_output;
  logic [15:0]                  window_count;

  modport master (
    output input_valid, data_in, ready_for_output,
    input  read_request, output_valid, data_out, window_count
  );

  modport slave (
    input  input_valid, data_in, ready_for_output,
    output read_request, output_valid, data_out, window_count
  );

endinterface

// File: rtl/sample_decimator.sv
// Block-average decimator sitting directly behind a FIFO; define
// SAMPLE_DECIMATOR_ROUND_EN for round-half-up instead of floor.
module sample_decimator
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DECIMATION = DEFAULT_DECIMATION
) (
  input logic               clk,
  input logic               reset,
  sample_decimator_if.slave bus
);

  localparam int SHIFT = $clog2(DECIMATION);
  localparam int SUM_W = DATA_WIDTH + SHIFT;
  localparam int CNT_W = SHIFT + 1;

  if (DECIMATION < 2 || DECIMATION > 256 || (DECIMATION & (DECIMATION - 1)) != 0) begin : g_bad_decimation
    $error("DECIMATION must be a power of two in 2..256");
  end

  dec_state_t               state, state_next;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  sum_next;
  logic [CNT_W-1:0]         count;
  logic                     pending;
  logic                     run;
  logic signed [DATA_WIDTH-1:0] data_out_q;
  logic signed [DATA_WIDTH-1:0] avg;
  logic [15:0]              window_count;
  logic [CNT_W:0]           outstanding;
  logic                     take;
  logic                     last;

  assign sum_next    = sum + SUM_W'(bus.data_in);
  assign outstanding = {1'b0, count} + {{CNT_W{1'b0}}, pending};
  assign take        = (state == ST_ACCUM) && bus.input_valid && (count < CNT_W'(DECIMATION));
  assign last        = take && (count == CNT_W'(DECIMATION - 1));

  // Sum is one bit wider per halving, so the half-LSB add cannot overflow.
`ifdef SAMPLE_DECIMATOR_ROUND_EN
  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(DECIMATION / 2);
  logic signed [SUM_W-1:0] sum_rounded;
  assign sum_rounded = sum_next + HALF;
  assign avg         = DATA_WIDTH'(sum_rounded >>> SHIFT);
`else
  assign avg         = DATA_WIDTH'(sum_next >>> SHIFT);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_ACCUM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ACCUM: if (last) state_next = ST_EMIT;
      ST_EMIT:  if (bus.ready_for_output) state_next = ST_ACCUM;
      default:  state_next = ST_ACCUM;
    endcase
  end

  // run holds off requests until the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum          <= '0;
      count        <= '0;
      pending      <= 1'b0;
      run          <= 1'b0;
      data_out_q   <= '0;
      window_count <= '0;
    end else begin
      run     <= 1'b1;
      pending <= bus.read_request;
      if (take) begin
        sum   <= sum_next;
        count <= count + 1'b1;
        if (last) data_out_q <= avg;
      end else if (state == ST_EMIT && bus.ready_for_output) begin
        sum          <= '0;
        count        <= '0;
        window_count <= window_count + 16'd1;
      end
    end
  end

  assign bus.read_request = run && (state == ST_ACCUM) && (outstanding < (CNT_W + 1)'(DECIMATION));
  assign bus.output_valid = (state == ST_EMIT);
  assign bus.data_out     = data_out_q;
  assign bus.window_count = window_count;

endmodule

// File: tb/tb_sample_decimator.sv
// Directed bench for sample_decimator (16-bit, decimate by 4) with a FIFO model.
module tb_sample_decimator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  int   reads = 0;
  int   tick_count = 0;
  int   last_iv_tick = -1;
  logic block_en = 1'b0;
  logic signed [15:0] fifo_q[$];
  logic signed [15:0] held;

  sample_decimator_if #(.DATA_WIDTH(16)) bus ();

  sample_decimator #(.DATA_WIDTH(16), .DECIMATION(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: a request seen before the edge returns data after it, unless the FIFO is empty.
  task automatic tick();
    logic req;
    logic blocked;
    req = bus.read_request;
    blocked = block_en && (tick_count % 3 == 1);
    @(posedge clk);
    #1;
    tick_count++;
    if (req && !blocked && fifo_q.size() > 0) begin
      bus.input_valid = 1'b1;
      bus.data_in = fifo_q.pop_front();
      reads++;
      last_iv_tick = tick_count;
    end else begin
      bus.input_valid = 1'b0;
    end
  endtask

  task automatic run_window(input string tag, input logic signed [15:0] exp_avg, input int exp_left);
    int r0;
    r0 = reads;
    for (int t = 0; t < 60 && !bus.output_valid; t++) tick();
    chk({tag, "_valid"}, 32'(bus.output_valid), 32'd1);
    chk({tag, "_latency"}, last_iv_tick, tick_count - 1);
    chk({tag, "_data"}, bus.data_out, exp_avg);
    chk({tag, "_reads"}, reads - r0, 4);
    chk({tag, "_left"}, fifo_q.size(), exp_left);
  endtask

  task automatic accept(input string tag, input logic [15:0] exp_wc);
    bus.ready_for_output = 1'b1;
    tick();
    bus.ready_for_output = 1'b0;
    chk({tag, "_acc_valid"}, 32'(bus.output_valid), 32'd0);
    chk({tag, "_acc_wc"}, bus.window_count, exp_wc);
  endtask

  initial begin
    int r0;
    bus.input_valid = 1'b0;
    bus.data_in = '0;
    bus.ready_for_output = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_request", 32'(bus.read_request), 32'd0);
    chk("rst_output_valid", 32'(bus.output_valid), 32'd0);
    chk("rst_data_out", bus.data_out, 32'd0);
    chk("rst_window_count", bus.window_count, 32'd0);

    fifo_q = '{16'sd1, 16'sd2, 16'sd3, 16'sd6};
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_no_request", 32'(bus.read_request), 32'd0);
    tick();
    chk("rel_first_request", 32'(bus.read_request), 32'd1);
    run_window("w1236", 16'sd3, 0);
    chk("w1236_wc_before", bus.window_count, 32'd0);
    accept("w1236", 16'd1);

`ifdef SAMPLE_DECIMATOR_ROUND_EN
    fifo_q = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    run_window("w1234", 16'sd3, 0);
    accept("w1234", 16'd2);
    fifo_q = '{-16'sd1, -16'sd1, -16'sd1, -16'sd2};
    run_window("wneg", -16'sd1, 0);
    accept("wneg", 16'd3);
`else
    fifo_q = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    run_window("w1234", 16'sd2, 0);
    accept("w1234", 16'd2);
    fifo_q = '{-16'sd1, -16'sd1, -16'sd1, -16'sd2};
    run_window("wneg", -16'sd2, 0);
    accept("wneg", 16'd3);
`endif

    fifo_q = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
    run_window("wmax", 16'sh7FFF, 0);
    accept("wmax", 16'd4);
    fifo_q = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};
    run_window("wmin", 16'sh8000, 0);
    accept("wmin", 16'd5);

    // Hold in EMIT with data waiting in the FIFO: nothing may be read.
    fifo_q = '{16'sd5, 16'sd5, 16'sd5, 16'sd5};
    run_window("whold", 16'sd5, 0);
    fifo_q = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
    r0 = reads;
    held = 16'sd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(bus.output_valid), 32'd1);
      chk("hold_data", bus.data_out, held);
      chk("hold_no_request", 32'(bus.read_request), 32'd0);
    end
    chk("hold_reads", reads - r0, 0);
    chk("hold_left", fifo_q.size(), 4);
    accept("whold", 16'd6);
    run_window("wnext", 16'sd25, 0);
    accept("wnext", 16'd7);

    block_en = 1'b1;
    fifo_q = '{16'sd7, 16'sd9, 16'sd11, 16'sd13, 16'sd99};
    run_window("wgap", 16'sd10, 1);
    block_en = 1'b0;
    fifo_q.delete();
    accept("wgap", 16'd8);

    fifo_q = '{16'sd100, 16'sd100};
    r0 = reads;
    for (int t = 0; t < 20 && reads - r0 < 2; t++) tick();
    chk("mid_reads", reads - r0, 2);
    reset = 1'b1;
    bus.input_valid = 1'b0;
    fifo_q.delete();
    #1;
    chk("mid_rst_request", 32'(bus.read_request), 32'd0);
    chk("mid_rst_valid", 32'(bus.output_valid), 32'd0);
    chk("mid_rst_data", bus.data_out, 32'd0);
    chk("mid_rst_wc", bus.window_count, 32'd0);
    fifo_q = '{16'sd8, 16'sd8, 16'sd8, 16'sd8};
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rel_no_request", 32'(bus.read_request), 32'd0);
    run_window("w8", 16'sd8, 0);
    accept("w8", 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
